imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/riscv_structures_pkg.sv | 21 ++
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/riscv_structures_pkg.sv
// riscv_structures: types shared by the instruction-memory loader.
// Build option: LOADER_CHECKSUM_EN adds a trailing checksum byte and the CHK state.
package riscv_structures;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHK  = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    // Byte address of word idx in a word-addressed image starting at base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles four little-endian bytes into one 32-bit word
// and raises word_valid for one cycle after the fourth byte.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_idx;
    logic [23:0] low_bytes;

    // Fourth byte of the current word is being accepted this cycle.
    assign word_last = byte_valid && (byte_idx == 2'd3);

    // Shift the first three bytes in from the top; the fourth completes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            low_bytes  <= 24'd0;
            word_valid <= 1'b0;
            word_data  <= 32'd0;
        end else begin
            word_valid <= word_last;
            if (clear) begin
                byte_idx <= 2'd0;
            end else if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                if (word_last) begin
                    word_data <= {byte_data, low_bytes};
                end else begin
                    low_bytes <= {byte_data, low_bytes[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory
// while holding the core stalled.
// Build option: LOADER_CHECKSUM_EN expects an XOR checksum byte after the payload.
//
// Handshake: a byte is transferred on a rising edge where in_valid && in_ready;
// the sender keeps in_data stable while in_valid is high and not yet accepted.
// in_ready depends only on the state, never on in_valid.
module imem_loader
    import riscv_structures::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          start,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output loader_state_t dbg_state
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    loader_state_t state_q, state_d;
    logic [15:0]   len_q;
    logic [15:0]   word_idx;
    logic [15:0]   len_full;
    logic          accept;
    logic          restart;
    logic          data_byte;
    logic          word_last;
    logic          last_word;

    assign in_ready  = (state_q != DONE) && (state_q != ERR);
    assign accept    = in_valid && in_ready;
    assign restart   = start && ((state_q == DONE) || (state_q == ERR));
    assign data_byte = accept && (state_q == DATA);
    assign len_full  = {in_data, len_q[7:0]};
    assign last_word = (word_idx == len_q - 16'd1);

    assign cpu_hold  = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign dbg_state = state_q;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .word_last  (word_last),
        .word_valid (mem_we),
        .word_data  (mem_wdata)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q;

    // Running XOR over every payload byte of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 8'd0;
        end else if (restart) begin
            chk_q <= 8'd0;
        end else if (data_byte) begin
            chk_q <= chk_q ^ in_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LEN0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the frame leaves DATA on its final byte, so the last write
    // strobe lands in the first cycle of the following state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN0: begin
                if (in_valid) state_d = LEN1;
            end
            LEN1: begin
                if (in_valid) begin
                    if ({16'd0, len_full} > MAX_N) begin
                        state_d = ERR;
                    end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_last && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (in_valid) state_d = (in_data == chk_q) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start) state_d = LEN0;
            end
            default: state_d = LEN0;
        endcase
    end

    // Capture the 16-bit word count, low byte first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= 16'd0;
        end else if (accept && (state_q == LEN0)) begin
            len_q[7:0] <= in_data;
        end else if (accept && (state_q == LEN1)) begin
            len_q[15:8] <= in_data;
        end
    end

    // Word counter and write address; the address is registered alongside
    // the packer's word so both change together with mem_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= 16'd0;
            mem_addr <= BASE_ADDR;
        end else if (restart) begin
            word_idx <= 16'd0;
        end else if (word_last) begin
            mem_addr <= word_addr(BASE_ADDR, word_idx);
            word_idx <= word_idx + 16'd1;
        end
    end

endmodule
